dpc_frame_ctrl: RTL and testbench

Frame-level sequencer for the dead-pixel correction datapath. It arms on a software start and admits input only from a start-of-frame (SOF) beat. It freezes the correction-enable setting for the whole frame, checks the frame geometry, and waits for the corrector pipeline to drain. At each frame end it publishes per-frame statistics and a done pulse. It sits beside the corrector: it snoops the input and output AXI-Stream handshakes and drives the corrector's enable and the upstream input gate.

---
 rtl/dpc_frame_ctrl_pkg.sv | 18 +
 rtl/dpc_frame_ctrl_if.sv | 27 ++
 rtl/dpc_geom_checker.sv | 77 +++++++
 rtl/dpc_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_dpc_frame_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpc_frame_ctrl_pkg.sv
// Shared types and default geometry for the dead-pixel-correction frame controller.
package dpc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DefFrameWidth   = 640;
    localparam int unsigned DefFrameHeight  = 512;
    localparam int unsigned DefCntWidth     = 10;
    localparam int unsigned DefBpcntWidth   = 20;
    localparam int unsigned DefDrainTimeout = 4096;

endpackage

// File: rtl/dpc_frame_ctrl_if.sv
// Snooped corrector AXI-Stream handshakes plus the gate/enable driven back to the corrector.
interface dpc_frame_ctrl_if;

    logic s_axis_tvalid;
    logic s_axis_tready;
    logic s_axis_tuser;
    logic s_axis_tlast;
    logic m_axis_tvalid;
    logic m_axis_tready;
    logic m_axis_tlast;
    logic bp_corrected;
    logic gate_open;
    logic dpc_enable;

    modport master (
        output s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast,
        output m_axis_tvalid, m_axis_tready, m_axis_tlast, bp_corrected,
        input  gate_open, dpc_enable
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast,
        input  m_axis_tvalid, m_axis_tready, m_axis_tlast, bp_corrected,
        output gate_open, dpc_enable
    );

endinterface

// File: rtl/dpc_geom_checker.sv
// Input-side x/y counters: detects the last line of a frame and flags width/height errors.
module dpc_geom_checker
    import dpc_ctrl_pkg::*;
#(
    parameter int unsigned FrameWidth  = DefFrameWidth,
    parameter int unsigned FrameHeight = DefFrameHeight,
    parameter int unsigned CntWidth    = DefCntWidth
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic beat_i,
    input  logic tuser_i,
    input  logic tlast_i,
    input  logic in_run_i,
    input  logic clr_err_i,
    output logic frame_end_o,
    output logic err_width_o,
    output logic err_height_o
);

    localparam logic [CntWidth:0] LineLen    = (CntWidth + 1)'(FrameWidth);
    localparam logic [CntWidth:0] FrameLines = (CntWidth + 1)'(FrameHeight);
    localparam logic [CntWidth:0] One        = (CntWidth + 1)'(1);

    logic [CntWidth-1:0] x_q, x_d, y_q, y_d, x_base, y_base;
    logic [CntWidth:0]   x_inc, y_inc;
    logic                wrong_len, early_sof;
    logic                err_width_q, err_height_q;

    // An SOF beat restarts the frame before its own pixel (and any EOL) is counted.
    assign x_base    = tuser_i ? '0 : x_q;
    assign y_base    = tuser_i ? '0 : y_q;
    assign x_inc     = {1'b0, x_base} + One;
    assign y_inc     = {1'b0, y_base} + One;
    assign early_sof = beat_i & tuser_i & in_run_i & ({1'b0, y_q} < FrameLines);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        wrong_len   = 1'b0;
        frame_end_o = 1'b0;
        if (beat_i) begin
            if (tlast_i) begin
                wrong_len   = (x_inc != LineLen);
                x_d         = '0;
                y_d         = y_inc[CntWidth-1:0];
                frame_end_o = (y_inc == FrameLines);
            end else begin
                x_d = x_inc[CntWidth-1:0];
                y_d = y_base;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q          <= '0;
            y_q          <= '0;
            err_width_q  <= 1'b0;
            err_height_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (clr_err_i) begin
                err_width_q  <= 1'b0;
                err_height_q <= 1'b0;
            end else begin
                if (wrong_len) err_width_q <= 1'b1;
                if (early_sof) err_height_q <= 1'b1;
            end
        end
    end

    assign err_width_o  = err_width_q;
    assign err_height_o = err_height_q;

endmodule

// File: rtl/dpc_frame_ctrl.sv
// Frame sequencer beside the dead-pixel corrector: arms on start, freezes the enable per
// frame, waits for the pipeline to drain and publishes per-frame statistics.
module dpc_frame_ctrl
    import dpc_ctrl_pkg::*;
#(
    parameter int unsigned FrameWidth   = DefFrameWidth,
    parameter int unsigned FrameHeight  = DefFrameHeight,
    parameter int unsigned CntWidth     = DefCntWidth,
    parameter int unsigned BpcntWidth   = DefBpcntWidth,
    parameter int unsigned DrainTimeout = DefDrainTimeout
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_start_i,
    input  logic                  cfg_stop_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cfg_enable_i,
    dpc_frame_ctrl_if.slave       axis_io,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_cnt_o,
    output logic [BpcntWidth-1:0] bp_count_last_o,
    output logic                  err_width_o,
    output logic                  err_height_o,
    output logic                  err_timeout_o
);

    localparam int unsigned       DrainW     = $clog2(DrainTimeout + 1);
    localparam logic [DrainW-1:0] DrainLast  = DrainW'(DrainTimeout - 1);
    localparam logic [CntWidth:0] FrameLines = (CntWidth + 1)'(FrameHeight);

    state_e                  state_q, state_d;
    logic                    gate_open, in_acc, sof_acc, out_acc, counting, out_eol;
    logic                    start_ok, frame_end, lines_done, drain_expired;
    logic [CntWidth:0]       olines_q, olines_d;
    logic [BpcntWidth-1:0]   bp_q, bp_d, bp_last_q;
    logic [DrainW-1:0]       drain_q;
    logic [15:0]             frame_cnt_q;
    logic                    enable_q, stop_q, err_timeout_q;

    assign gate_open = (state_q == StRun) | ((state_q == StArm) & axis_io.s_axis_tuser);
    assign in_acc    = axis_io.s_axis_tvalid & axis_io.s_axis_tready & gate_open;
    assign sof_acc   = in_acc & axis_io.s_axis_tuser;
    assign out_acc   = axis_io.m_axis_tvalid & axis_io.m_axis_tready;
    assign counting  = (state_q == StRun) | (state_q == StDrain);
    assign out_eol   = out_acc & axis_io.m_axis_tlast & counting;
    assign start_ok  = (state_q == StIdle) & cfg_start_i & ~cfg_stop_i;

    assign axis_io.gate_open  = gate_open;
    assign axis_io.dpc_enable = enable_q;

    dpc_geom_checker #(
        .FrameWidth  (FrameWidth),
        .FrameHeight (FrameHeight),
        .CntWidth    (CntWidth)
    ) u_geom (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .beat_i       (in_acc),
        .tuser_i      (axis_io.s_axis_tuser),
        .tlast_i      (axis_io.s_axis_tlast),
        .in_run_i     (state_q == StRun),
        .clr_err_i    (start_ok),
        .frame_end_o  (frame_end),
        .err_width_o  (err_width_o),
        .err_height_o (err_height_o)
    );

    // Output EOLs and corrected beats can already appear during RUN; count them from the SOF.
    always_comb begin
        olines_d = sof_acc ? '0 : olines_q;
        bp_d     = sof_acc ? '0 : bp_q;
        if (out_eol) olines_d = olines_d + (CntWidth + 1)'(1);
        if (out_acc && axis_io.bp_corrected && counting && !(&bp_d)) begin
            bp_d = bp_d + BpcntWidth'(1);
        end
    end

    assign lines_done    = (olines_d >= FrameLines);
    assign drain_expired = (drain_q == DrainLast);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StArm;
            StArm: begin
                if (cfg_stop_i)   state_d = StIdle;
                else if (sof_acc) state_d = frame_end ? StDrain : StRun;
            end
            StRun:   if (frame_end) state_d = StDrain;
            StDrain: if (lines_done || drain_expired) state_d = StDone;
            StDone:  state_d = (cfg_continuous_i && !stop_q && !cfg_stop_i) ? StArm : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != StIdle);
        frame_done_o = (state_q == StDone);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            olines_q      <= '0;
            bp_q          <= '0;
            bp_last_q     <= '0;
            drain_q       <= '0;
            frame_cnt_q   <= '0;
            enable_q      <= 1'b0;
            stop_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            olines_q <= olines_d;
            bp_q     <= bp_d;
            drain_q  <= (state_q == StDrain) ? drain_q + DrainW'(1) : '0;
            if (sof_acc) enable_q <= cfg_enable_i;
            if (state_q == StRun || state_q == StDrain || state_q == StDone) begin
                if (cfg_stop_i) stop_q <= 1'b1;
            end else begin
                stop_q <= 1'b0;
            end
            if (start_ok) begin
                err_timeout_q <= 1'b0;
            end else if (state_q == StDrain && !lines_done && drain_expired) begin
                err_timeout_q <= 1'b1;
            end
            if (state_q == StDone) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                bp_last_q   <= bp_q;
            end
        end
    end

    assign frame_cnt_o     = frame_cnt_q;
    assign bp_count_last_o = bp_last_q;
    assign err_timeout_o   = err_timeout_q;

endmodule

// File: tb/tb_dpc_frame_ctrl.sv
// Randomised frame traffic against a frame-level model; a monitor scores every frame_done.
module tb_dpc_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DT = 40;

    typedef struct {
        bit en;
        int bp;
        int fcnt;
        bit ew;
        bit eh;
        bit et;
    } exp_t;

    typedef struct {
        int due;
        bit last;
        bit bp;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0, cfg_enable = 1'b0;
    logic        busy, frame_done, err_width, err_height, err_timeout;
    logic [15:0] frame_cnt;
    logic [19:0] bp_count_last;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    out_t out_q[$];
    int   frames_model = 0;
    bit   m_ew = 0, m_eh = 0, m_et = 0;

    dpc_frame_ctrl_if bus ();

    dpc_frame_ctrl #(
        .FrameWidth   (W),
        .FrameHeight  (H),
        .CntWidth     (10),
        .BpcntWidth   (20),
        .DrainTimeout (DT)
    ) dut (
        .aclk             (clk),
        .aresetn          (rst_n),
        .cfg_start_i      (cfg_start),
        .cfg_stop_i       (cfg_stop),
        .cfg_continuous_i (cfg_continuous),
        .cfg_enable_i     (cfg_enable),
        .axis_io          (bus),
        .busy_o           (busy),
        .frame_done_o     (frame_done),
        .frame_cnt_o      (frame_cnt),
        .bp_count_last_o  (bp_count_last),
        .err_width_o      (err_width),
        .err_height_o     (err_height),
        .err_timeout_o    (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Corrector stand-in: replays each accepted input beat on the output about 5 cycles later.
    initial begin
        bit accepted;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.bp_corrected  = 1'b0;
        forever begin
            @(posedge clk);
            accepted = bus.m_axis_tvalid && bus.m_axis_tready;
            #1;
            if (accepted && out_q.size() > 0) void'(out_q.pop_front());
            bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            if (out_q.size() > 0 && out_q[0].due <= cyc) begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tlast  = out_q[0].last;
                bus.bp_corrected  = out_q[0].bp;
            end else begin
                bus.m_axis_tvalid = 1'b0;
                bus.m_axis_tlast  = 1'b0;
                bus.bp_corrected  = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_frame_done", frame_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_dpc_enable", bus.dpc_enable, e.en);
                    check("done_err_width", err_width, e.ew);
                    check("done_err_height", err_height, e.eh);
                    check("done_err_timeout", err_timeout, e.et);
                    @(negedge clk);
                    check("frame_done_pulse_width", frame_done, 0);
                    check("frame_cnt", frame_cnt, e.fcnt);
                    check("bp_count_last", bp_count_last, e.bp);
                end
            end
        end
    end

    task automatic do_reset();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_continuous = 1'b0;
        cfg_enable = 1'b0;
        rst_n = 1'b0;
        out_q.delete();
        exp_q.delete();
        frames_model = 0;
        m_ew = 0;
        m_eh = 0;
        m_et = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        m_ew = 0;
        m_eh = 0;
        m_et = 0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        @(posedge clk);
        #1 cfg_stop = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("all_expected_frames_done", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; a complete frame also pushes its expected statistics.
    task automatic send_frame(input int short_line, input int lines, input int nbp,
                              input bit withhold, input bit toggle_en);
        int   lens[$];
        int   npix = 0;
        int   p = 0;
        int   rot;
        bit   en;
        exp_t e;
        for (int l = 0; l < lines; l++) begin
            lens.push_back((l == short_line) ? W - 1 : W);
            npix += lens[l];
        end
        rot = $urandom_range(0, npix - 1);
        en = cfg_enable;
        if (short_line >= 0 && short_line < lines) m_ew = 1;
        if (withhold) m_et = 1;
        if (lines == H) begin
            frames_model++;
            e = '{en: en, bp: nbp, fcnt: frames_model, ew: m_ew, eh: m_eh, et: m_et};
            exp_q.push_back(e);
        end
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < lens[l]; x++) begin
                bit acc = 0;
                int guard = 0;
                bus.s_axis_tuser = (l == 0 && x == 0);
                bus.s_axis_tlast = (x == lens[l] - 1);
                while (!acc) begin
                    bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
                    bus.s_axis_tready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = bus.s_axis_tvalid && bus.s_axis_tready && bus.gate_open;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (guard > 500) begin
                        bad++;
                        $display("FAIL input_beat_stall: got no accept expected accept");
                        $fatal(1, "input beat never accepted");
                    end
                end
                out_q.push_back('{due: cyc + 5, last: bus.s_axis_tlast && !withhold,
                                  bp: (((p + rot) % npix) < nbp)});
                p++;
            end
            if (l == 0 && toggle_en) cfg_enable = ~cfg_enable;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (toggle_en) begin
            @(negedge clk);
            check("dpc_enable_frozen_mid_frame", bus.dpc_enable, en);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tready = 1'b1;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_bp_count_last", bp_count_last, 0);
        check("reset_errors", {err_width, err_height, err_timeout}, 0);
        check("reset_gate_open", bus.gate_open, 0);
        check("reset_dpc_enable", bus.dpc_enable, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.s_axis_tuser = 1'b1;
        @(negedge clk);
        check("idle_gate_closed_on_sof", bus.gate_open, 0);
        @(posedge clk);
        #1 bus.s_axis_tuser = 1'b0;

        // Single 4x3 frame, one-shot.
        pulse_start();
        send_frame(-1, H, 0, 0, 0);
        wait_drain();
        check("t1_idle_after_frame", busy, 0);

        // Enable frozen per frame, re-sampled at the next SOF in continuous mode.
        do_reset();
        cfg_continuous = 1'b1;
        cfg_enable = 1'b1;
        pulse_start();
        send_frame(-1, H, 2, 0, 1);
        send_frame(-1, H, 1, 0, 0);
        wait_drain();
        pulse_stop();
        @(negedge clk);
        check("t2_stopped_from_arm", busy, 0);
        @(posedge clk);
        #1;

        // Short second line.
        do_reset();
        pulse_start();
        send_frame(1, H, 3, 0, 0);
        wait_drain();
        check("t3_err_width_sticky", err_width, 1);
        pulse_start();
        @(negedge clk);
        check("t3_start_clears_err_width", err_width, 0);
        @(posedge clk);
        #1 pulse_stop();

        // Early SOF after two lines, then a full frame.
        do_reset();
        pulse_start();
        send_frame(-1, 2, 2, 0, 0);
        repeat (30) @(posedge clk);
        #1 m_eh = 1;
        send_frame(-1, H, 4, 0, 0);
        wait_drain();

        // Seven corrected pixels; then output EOLs withheld until the drain timeout.
        do_reset();
        pulse_start();
        send_frame(-1, H, 7, 0, 0);
        wait_drain();
        pulse_start();
        send_frame(-1, H, $urandom_range(0, 12), 1, 0);
        wait_drain();

        // Random continuous frames.
        cfg_continuous = 1'b1;
        pulse_start();
        for (int f = 0; f < 4; f++) begin
            int sl;
            cfg_enable = 1'($urandom_range(0, 1));
            sl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, H - 1) : -1;
            send_frame(sl, H, $urandom_range(0, 11), 0, 0);
        end
        wait_drain();
        pulse_stop();

        // Stop during RUN in continuous mode.
        do_reset();
        cfg_continuous = 1'b1;
        cfg_enable = 1'b1;
        pulse_start();
        fork
            send_frame(-1, H, 5, 0, 0);
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(bus.gate_open && !bus.s_axis_tuser) && n < 300);
                @(posedge clk);
                #1 cfg_stop = 1'b1;
                @(posedge clk);
                #1 cfg_stop = 1'b0;
            end
        join
        wait_drain();
        check("t6_idle_after_stop", busy, 0);
        cfg_start = 1'b1;
        cfg_stop = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        cfg_stop = 1'b0;
        @(negedge clk);
        check("t6_start_stop_same_cycle", busy, 0);
        repeat (2) @(negedge clk);
        check("t6_still_idle", busy, 0);

        // Reset in the middle of a frame.
        @(posedge clk);
        #1 pulse_start();
        bus.s_axis_tready = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tuser = 1'b1;
        @(posedge clk);
        #1 bus.s_axis_tuser = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("t6_busy_mid_frame", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_gate_open", bus.gate_open, 0);
        check("midreset_dpc_enable", bus.dpc_enable, 0);
        check("midreset_frame_cnt", frame_cnt, 0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_idle_after_release", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
